// File: rtl/itch_replace_pkg.sv
// itch_replace_pkg: field widths and the queued Replace event record.
// Adds a sequence number field when REPLACE_EVENT_QUEUE_SEQNUM_EN is defined.
package itch_replace_pkg;
    localparam int ORDER_REF_W = 64;
    localparam int SHARES_W    = 32;
    localparam int PRICE_W     = 32;
`ifdef REPLACE_EVENT_QUEUE_SEQNUM_EN
    localparam int SEQ_W       = 32;
    typedef struct packed {
        logic [ORDER_REF_W-1:0] old_ref;
        logic [ORDER_REF_W-1:0] new_ref;
        logic [SHARES_W-1:0]    shares;
        logic [PRICE_W-1:0]     price;
        logic [SEQ_W-1:0]       seq;
    } replace_event_t;
`else
    typedef struct packed {
        logic [ORDER_REF_W-1:0] old_ref;
        logic [ORDER_REF_W-1:0] new_ref;
        logic [SHARES_W-1:0]    shares;
        logic [PRICE_W-1:0]     price;
    } replace_event_t;
`endif
endpackage

// File: rtl/itch_sync_fifo.sv
// itch_sync_fifo: first-word-fall-through synchronous FIFO with wrap-bit pointers.
// Push while full is accepted only alongside a pop; head reads 0 when empty.
module itch_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic             w_pop;
    logic             w_push;
    assign o_count = r_wr - r_rd;
    assign o_full  = o_count[AW];
    assign o_empty = r_wr == r_rd;
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_data  = o_empty ? '0 : r_mem[r_rd[AW-1:0]];
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
        end
    end
endmodule

// File: rtl/replace_event_queue.sv
// replace_event_queue: buffers decoded Replace messages for the book stage, counting drops and invalids.
// Define REPLACE_EVENT_QUEUE_SEQNUM_EN to tag entries with a message sequence number (out_seq).
module replace_event_queue
    import itch_replace_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DROP_CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     replace_internal_valid,
    input  logic                     replace_packet_invalid,
    input  logic [ORDER_REF_W-1:0]   replace_old_order_ref,
    input  logic [ORDER_REF_W-1:0]   replace_new_order_ref,
    input  logic [SHARES_W-1:0]      replace_shares,
    input  logic [PRICE_W-1:0]       replace_price,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ORDER_REF_W-1:0]   out_old_order_ref,
    output logic [ORDER_REF_W-1:0]   out_new_order_ref,
    output logic [SHARES_W-1:0]      out_shares,
    output logic [PRICE_W-1:0]       out_price,
`ifdef REPLACE_EVENT_QUEUE_SEQNUM_EN
    output logic [SEQ_W-1:0]         out_seq,
`endif
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic                     queue_overflow,
    output logic [DROP_CNT_W-1:0]    drop_count,
    output logic [DROP_CNT_W-1:0]    invalid_count
);
    replace_event_t          w_in;
    replace_event_t          w_head;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;
    logic                    w_drop;
    logic                    r_ovf;
    logic [DROP_CNT_W-1:0]   r_drop;
    logic [DROP_CNT_W-1:0]   r_inv;
`ifdef REPLACE_EVENT_QUEUE_SEQNUM_EN
    logic [SEQ_W-1:0]        r_seq;
    assign w_in    = '{old_ref: replace_old_order_ref, new_ref: replace_new_order_ref,
                       shares: replace_shares, price: replace_price, seq: r_seq};
    assign out_seq = w_head.seq;
`else
    assign w_in    = '{old_ref: replace_old_order_ref, new_ref: replace_new_order_ref,
                       shares: replace_shares, price: replace_price};
`endif
    assign out_valid         = ~w_empty;
    assign w_pop             = out_valid & out_ready;
    // A full queue only loses the message when nothing leaves on the same edge.
    assign w_drop            = replace_internal_valid & w_full & ~w_pop;
    assign out_old_order_ref = w_head.old_ref;
    assign out_new_order_ref = w_head.new_ref;
    assign out_shares        = w_head.shares;
    assign out_price         = w_head.price;
    assign queue_overflow    = r_ovf;
    assign drop_count        = r_drop;
    assign invalid_count     = r_inv;
    itch_sync_fifo #(
        .WIDTH ($bits(replace_event_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (replace_internal_valid),
        .i_pop   (out_ready),
        .i_data  (w_in),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (queue_count)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf  <= 1'b0;
            r_drop <= '0;
            r_inv  <= '0;
        end else begin
            if (w_drop) r_ovf <= 1'b1;
            if (w_drop && ~&r_drop) r_drop <= r_drop + 1'b1;
            if (replace_packet_invalid && ~&r_inv) r_inv <= r_inv + 1'b1;
        end
    end
`ifdef REPLACE_EVENT_QUEUE_SEQNUM_EN
    always_ff @(posedge clk) begin
        if (rst) r_seq <= '0;
        else if (replace_internal_valid) r_seq <= r_seq + 1'b1;
    end
`endif
endmodule

// File: tb/tb_replace_event_queue.sv
// tb_replace_event_queue: directed plus random stimulus against a queue-based reference model.
// A negedge monitor compares every popped head and the status outputs with the model.
module tb_replace_event_queue;
    import itch_replace_pkg::*;
    localparam int DEPTH = 8;
    localparam int DW    = 16;
    logic        clk = 1'b0;
    logic        rst;
    logic        replace_internal_valid;
    logic        replace_packet_invalid;
    logic [63:0] replace_old_order_ref;
    logic [63:0] replace_new_order_ref;
    logic [31:0] replace_shares;
    logic [31:0] replace_price;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_old_order_ref;
    logic [63:0] out_new_order_ref;
    logic [31:0] out_shares;
    logic [31:0] out_price;
    logic [3:0]  queue_count;
    logic        queue_overflow;
    logic [DW-1:0] drop_count;
    logic [DW-1:0] invalid_count;
`ifdef REPLACE_EVENT_QUEUE_SEQNUM_EN
    logic [31:0] out_seq;
`endif
    int n_cmp = 0;
    int n_err = 0;
    replace_event_t sb[$];
    int          m_cnt = 0;
    int          m_drop = 0;
    int          m_inv = 0;
    bit          m_ovf = 0;
    logic [31:0] m_seq = 0;

    replace_event_queue #(.DEPTH(DEPTH), .DROP_CNT_W(DW)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .replace_internal_valid (replace_internal_valid),
        .replace_packet_invalid (replace_packet_invalid),
        .replace_old_order_ref  (replace_old_order_ref),
        .replace_new_order_ref  (replace_new_order_ref),
        .replace_shares         (replace_shares),
        .replace_price          (replace_price),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .out_old_order_ref      (out_old_order_ref),
        .out_new_order_ref      (out_new_order_ref),
        .out_shares             (out_shares),
        .out_price              (out_price),
`ifdef REPLACE_EVENT_QUEUE_SEQNUM_EN
        .out_seq                (out_seq),
`endif
        .queue_count            (queue_count),
        .queue_overflow         (queue_overflow),
        .drop_count             (drop_count),
        .invalid_count          (invalid_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the queue holds what should come out, occupancy is a plain integer.
    always @(posedge clk) begin
        bit pop;
        bit acc;
        replace_event_t e;
        if (rst) begin
            m_cnt = 0; m_drop = 0; m_inv = 0; m_ovf = 0; m_seq = 0;
            sb.delete();
        end else begin
            pop = (m_cnt > 0) && out_ready;
            acc = replace_internal_valid && (m_cnt < DEPTH || pop);
            if (acc) begin
                e.old_ref = replace_old_order_ref;
                e.new_ref = replace_new_order_ref;
                e.shares  = replace_shares;
                e.price   = replace_price;
`ifdef REPLACE_EVENT_QUEUE_SEQNUM_EN
                e.seq     = m_seq;
`endif
                sb.push_back(e);
            end else if (replace_internal_valid) begin
                m_ovf = 1;
                if (m_drop < (1 << DW) - 1) m_drop++;
            end
            m_cnt = m_cnt + int'(acc) - int'(pop);
            if (replace_packet_invalid && m_inv < (1 << DW) - 1) m_inv++;
            if (replace_internal_valid) m_seq++;
        end
    end

    always @(negedge clk) begin
        replace_event_t e;
        chk("out_valid", 64'(out_valid), 64'(m_cnt > 0));
        chk("queue_count", 64'(queue_count), 64'(m_cnt));
        chk("drop_count", 64'(drop_count), 64'(m_drop));
        chk("invalid_count", 64'(invalid_count), 64'(m_inv));
        chk("queue_overflow", 64'(queue_overflow), 64'(m_ovf));
        if (!out_valid) begin
            chk("empty_head", out_old_order_ref | out_new_order_ref | 64'(out_shares) | 64'(out_price), 64'd0);
        end else if (out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_pop", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("old_ref", out_old_order_ref, e.old_ref);
                chk("new_ref", out_new_order_ref, e.new_ref);
                chk("shares", 64'(out_shares), 64'(e.shares));
                chk("price", 64'(out_price), 64'(e.price));
`ifdef REPLACE_EVENT_QUEUE_SEQNUM_EN
                chk("seq", 64'(out_seq), 64'(e.seq));
`endif
            end
        end
    end

    task automatic drive(input bit v, input bit inv, input bit rdy, input logic [63:0] o,
                         input logic [63:0] n, input logic [31:0] s, input logic [31:0] p);
        replace_internal_valid = v;
        replace_packet_invalid = inv;
        out_ready              = rdy;
        replace_old_order_ref  = o;
        replace_new_order_ref  = n;
        replace_shares         = s;
        replace_price          = p;
        @(posedge clk);
        #1;
    endtask

    task automatic rnd(input bit v, input bit inv, input bit rdy);
        drive(v, inv, rdy, {$urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom);
    endtask

    initial begin
        int rp;
        rst = 1'b1;
        repeat (2) rnd(0, 0, 0);
        rst = 1'b0;
        rnd(0, 0, 0);
        drive(1, 0, 0, 64'h1122334455667788, 64'h99AABBCCDDEEFF00, 32'h64, 32'h000F4240);
        rnd(0, 0, 0);
        rnd(0, 0, 1);
        rnd(0, 0, 1);
        for (int i = 1; i <= 9; i++) drive(1, 0, 0, 64'(i), 64'(i + 100), 32'(i), 32'(i * 3));
        rnd(0, 0, 0);
        drive(1, 0, 1, 64'h55, 64'h155, 32'h55, 32'h555);
        repeat (10) rnd(0, 0, 1);
        rnd(0, 1, 0);
        rnd(1, 1, 0);
        rnd(0, 1, 0);
        repeat (3) rnd(1, 0, 0);
        rst = 1'b1;
        rnd(1, 0, 0);
        rst = 1'b0;
        repeat (2) rnd(0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            rp = (i / 200) % 3 == 0 ? 10 : (i / 200) % 3 == 1 ? 50 : 90;
            if (i == 1500) rst = 1'b1;
            rnd($urandom_range(99) < 60, $urandom_range(99) < 10, $urandom_range(99) < rp);
            rst = 1'b0;
        end
        repeat (DEPTH + 4) rnd(0, 0, 1);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/replace_event_queue.md
Name: replace_event_queue

Overview:
- Downstream stage of the Replace Order ('U') decoder.
- Captures each completed Replace message (one-cycle valid pulse plus old ref, new ref, shares and price) into a small synchronous FIFO.
- Presents the captured messages to the order-book update logic over a valid/ready interface.
- Counts malformed packets reported by the decoder and messages dropped on overflow, so the book stage can stall without losing decoder results.

Parameters:
- DEPTH, 8: number of queued entries; power of 2, minimum 2.
- DROP_CNT_W, 16: width of the saturating drop and invalid counters.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- replace_internal_valid  input  1  one-cycle pulse; the message is complete and the fields are stable this cycle
- replace_packet_invalid  input  1  one-cycle pulse; the decoder detected an overrun or truncated message
- replace_old_order_ref  input  64  original order reference
- replace_new_order_ref  input  64  new order reference
- replace_shares  input  32  updated shares
- replace_price  input  32  updated price
- out_valid  output  1  head entry available
- out_ready  input  1  consumer accepts the head entry this cycle
- out_old_order_ref  output  64  head old ref
- out_new_order_ref  output  64  head new ref
- out_shares  output  32  head shares
- out_price  output  32  head price
- queue_count  output  $clog2(DEPTH)+1  occupancy
- queue_overflow  output  1  sticky; set when any message is dropped
- drop_count  output  DROP_CNT_W  messages dropped due to a full queue; saturating
- invalid_count  output  DROP_CNT_W  replace_packet_invalid pulses seen; saturating

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high, sampled on the posedge of clk.
- Reset values: pointers 0, queue_count 0, out_valid 0, queue_overflow 0, drop_count 0, invalid_count 0. Head data outputs read as 0 while the queue is empty.
- Push: on a clk edge where replace_internal_valid=1 and a push is permitted, the four fields are written at wr_ptr and wr_ptr advances, wrapping modulo DEPTH.
- Pop: on a clk edge where out_valid && out_ready, rd_ptr advances, wrapping modulo DEPTH.
- Output timing: first-word-fall-through. The head is driven combinationally from storage at rd_ptr.
- Latency: out_valid rises the cycle after the push edge into an empty queue. There is no bypass of the same-cycle input.
- Push permitted when either:
  - queue_count < DEPTH, or
  - the queue is full and a pop occurs the same edge (simultaneous push and pop when full is accepted; occupancy stays DEPTH).
- Full with no pop and replace_internal_valid=1:
  - the message is discarded and storage is unchanged;
  - queue_overflow is set and held until rst;
  - drop_count increments, saturating at all-ones.
- Simultaneous push and pop when not full: both take effect; queue_count is unchanged.
- Pop when empty: out_ready is ignored; no pointer movement.
- Counting invalids: replace_packet_invalid=1 increments invalid_count, saturating. It never pushes an entry.
- Both pulses in one cycle: replace_internal_valid and replace_packet_invalid high together are handled independently — the push proceeds and the invalid is counted.
- Head stability: while out_valid=1 && out_ready=0, the head data stays stable. A push never alters the head entry.
- rst mid-operation:
  - all queued entries are discarded;
  - counters clear;
  - a valid pulse coincident with rst is ignored.
- Storage arrays need no reset; only pointers, counters and flags are reset.
- Occupancy tracking: queue_count is derived from pointers with one extra wrap bit (full when the indices are equal and the wrap bits differ).

Optional Feature:
- Macro: REPLACE_EVENT_QUEUE_SEQNUM_EN.
- When defined:
  - adds a 32-bit free-running message sequence counter, reset to 0;
  - the counter increments on every replace_internal_valid pulse, including dropped messages, wrapping at 2^32;
  - each accepted entry stores the counter value before increment;
  - adds output port out_seq (32 bits), the head's sequence number. Gaps in out_seq identify drops.
- When undefined: no counter, no out_seq port, no extra storage.

Decomposition:
- Package itch_replace_pkg holds:
  - constants ORDER_REF_W=64, SHARES_W=32, PRICE_W=32;
  - typedef replace_event_t, a packed struct of old_ref, new_ref, shares, price;
  - under the macro, the seq field and SEQ_W=32.
- Sub-module itch_sync_fifo:
  - generic width/depth FFT FIFO providing push, pop, full, empty and count;
  - the top level adds drop policy, counters and field unpacking.

Test Plan:
- Reset: assert rst for 2 cycles -> out_valid=0, queue_count=0, drop_count=0, invalid_count=0, queue_overflow=0.
- Single message: pulse valid with old=0x1122334455667788, new=0x99AABBCCDDEEFF00, shares=0x64, price=0x000F4240, out_ready=0 -> next cycle out_valid=1, head equals inputs, queue_count=1. Then out_ready=1 for one cycle -> out_valid=0.
- Fill and overflow (DEPTH=8): push 9 messages with out_ready=0 -> queue_count=8, drop_count=1, queue_overflow=1. Popping yields messages 1..8 in order; the 9th is absent.
- Full with simultaneous push and pop: full queue, out_ready=1 and a valid pulse on the same edge -> drop_count unchanged, queue_count stays 8, and the new message appears last.
- Invalid handling and mid-operation reset: 3 replace_packet_invalid pulses, one coincident with a valid pulse -> invalid_count=3 and 1 entry queued. Then rst with 4 entries queued -> empty queue and all counters 0.
- With REPLACE_EVENT_QUEUE_SEQNUM_EN: 10 pushes into DEPTH=8 with no pops -> popped out_seq values are 0..7, and the sequence counter reads 10.
